rv_instr_encoder_loader: RTL

Encoder counterpart of the CPU main decoder. It accepts decoded instruction fields (class, registers, funct, immediate) over a valid/ready stream and assembles legal RV32I 32-bit words. It writes those words sequentially into instruction memory through a registered write port with back-pressure. Bench and boot paths use it to preload programs containing exactly the opcodes the core decodes: lw, sw, R-type, branch, I-ALU, jal, jalr, lui and auipc.

---
 rtl/rv_instr_encoder_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rv_instr_encoder_loader.sv
// Purpose: encodes decoded RV32I fields into instruction words and streams them into instruction memory.
// Latency: an entry accepted in cycle N presents its write (mem_we/addr/wdata) in cycle N+1.
// Backpressure: in_ready falls while a write is pending and mem_ready is low; the write is held until accepted.
module rv_instr_encoder_loader #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cls,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  nwords_q;
    logic [CNT_W-1:0]  acc_cnt_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  err_cnt_q;

    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              fits12;
    logic              fits13;
    logic              fits21;
    logic              is_shift;
    logic              accept;
    logic              wr_done;
    logic [CNT_W-1:0]  acc_cnt_d;

    // Signed-range checks: every bit above the sign bit must equal the sign bit.
    assign fits12   = (&in_imm[31:11]) || (~|in_imm[31:11]);
    assign fits13   = (&in_imm[31:12]) || (~|in_imm[31:12]);
    assign fits21   = (&in_imm[31:20]) || (~|in_imm[31:20]);
    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    assign in_ready  = (state_q == LOAD) && (!mem_we_q || mem_ready);
    assign accept    = in_valid && in_ready;
    assign wr_done   = mem_we_q && mem_ready;
    assign acc_cnt_d = acc_cnt_q + CNT_W'(1);

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == LOAD) || (state_q == DRAIN);
    assign done      = done_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    // Assemble the instruction word for the presented class and decide whether it is legal.
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (in_cls)
            4'd0: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h03};
                enc_ok   = fits12;
            end
            4'd1: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'h23};
                enc_ok   = fits12;
            end
            4'd2: begin
                enc_word = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, 7'h33};
                enc_ok   = 1'b1;
            end
            4'd3: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'h63};
                enc_ok   = fits13 && !in_imm[0];
            end
            4'd4: begin
                if (is_shift) begin
                    enc_word = {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'h13};
                    enc_ok   = ~|in_imm[31:5];
                end else begin
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'h13};
                    enc_ok   = fits12;
                end
            end
            4'd5: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
                enc_ok   = fits21 && !in_imm[0];
            end
            4'd6: begin
                enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'h67};
                enc_ok   = fits12;
            end
            4'd7: begin
                enc_word = {in_imm[31:12], in_rd, 7'h37};
                enc_ok   = ~|in_imm[11:0];
            end
            4'd8: begin
                enc_word = {in_imm[31:12], in_rd, 7'h17};
                enc_ok   = ~|in_imm[11:0];
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // Session FSM together with the registered write port and error bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            nwords_q    <= '0;
            acc_cnt_q   <= '0;
            wr_cnt_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            // A completed write frees the port; a new accept below may refill it in the same cycle.
            if (wr_done) begin
                mem_we_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q     <= 1'b0;
                        err_cnt_q <= '0;
                        acc_cnt_q <= '0;
                        wr_cnt_q  <= '0;
                        nwords_q  <= num_words;
                        state_q   <= (num_words == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        acc_cnt_q <= acc_cnt_d;
                        if (enc_ok) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= BASE_ADDR + (ADDR_W'(wr_cnt_q) << 2);
                            mem_wdata_q <= enc_word;
                            wr_cnt_q    <= wr_cnt_q + CNT_W'(1);
                        end else begin
                            err_q <= 1'b1;
                            if (err_cnt_q != '1) begin
                                err_cnt_q <= err_cnt_q + CNT_W'(1);
                            end
                        end
                        if (acc_cnt_d == nwords_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!mem_we_q || wr_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
